// File: rtl/regfile_bank32.sv
// 32 x WIDTH general-purpose register bank feeding the 32:1 read selector.
// One byte-enabled write port, plus a bulk-clear sequencer that zeroes
// r1..r31 one register per cycle. r0 is hardwired to zero.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | accepting writes; iClr starts a clear sequence
// CLEAR | zeroing reg[cnt_q] each edge, cnt_q = 1..31; writes dropped
module regfile_bank32 #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iWe,
  input  logic [4:0]         iWaddr,
  input  logic [WIDTH-1:0]   iWdata,
  input  logic [WIDTH/8-1:0] iBe,
  input  logic               iClr,
  output logic               oWack,
  output logic               oBusy,
  output logic [WIDTH-1:0]   oR0,
  output logic [WIDTH-1:0]   oR1,
  output logic [WIDTH-1:0]   oR2,
  output logic [WIDTH-1:0]   oR3,
  output logic [WIDTH-1:0]   oR4,
  output logic [WIDTH-1:0]   oR5,
  output logic [WIDTH-1:0]   oR6,
  output logic [WIDTH-1:0]   oR7,
  output logic [WIDTH-1:0]   oR8,
  output logic [WIDTH-1:0]   oR9,
  output logic [WIDTH-1:0]   oR10,
  output logic [WIDTH-1:0]   oR11,
  output logic [WIDTH-1:0]   oR12,
  output logic [WIDTH-1:0]   oR13,
  output logic [WIDTH-1:0]   oR14,
  output logic [WIDTH-1:0]   oR15,
  output logic [WIDTH-1:0]   oR16,
  output logic [WIDTH-1:0]   oR17,
  output logic [WIDTH-1:0]   oR18,
  output logic [WIDTH-1:0]   oR19,
  output logic [WIDTH-1:0]   oR20,
  output logic [WIDTH-1:0]   oR21,
  output logic [WIDTH-1:0]   oR22,
  output logic [WIDTH-1:0]   oR23,
  output logic [WIDTH-1:0]   oR24,
  output logic [WIDTH-1:0]   oR25,
  output logic [WIDTH-1:0]   oR26,
  output logic [WIDTH-1:0]   oR27,
  output logic [WIDTH-1:0]   oR28,
  output logic [WIDTH-1:0]   oR29,
  output logic [WIDTH-1:0]   oR30,
  output logic [WIDTH-1:0]   oR31
);

  localparam int NB = WIDTH / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             wack_q, wack_d;
  // r0 has no storage; only r1..r31 are real flops.
  logic [WIDTH-1:0] regs_q [1:NREG-1];
  logic [WIDTH-1:0] regs_d [1:NREG-1];

  // Next-state logic: byte-enabled write in IDLE, one-register-per-cycle clear in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wack_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (iClr) begin
          // Clear wins over a simultaneous write; the write is dropped unacknowledged.
          state_d = CLEAR;
          cnt_d   = 5'd1;
        end else if (iWe) begin
          wack_d = 1'b1;
          for (int r = 1; r < NREG; r++) begin
            if (iWaddr == 5'(r)) begin
              for (int b = 0; b < NB; b++) begin
                if (iBe[b]) begin
                  regs_d[r][8*b +: 8] = iWdata[8*b +: 8];
                end
              end
            end
          end
        end
      end
      CLEAR: begin
        for (int r = 1; r < NREG; r++) begin
          if (cnt_q == 5'(r)) begin
            regs_d[r] = '0;
          end
        end
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State, counter, acknowledge and register storage; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      wack_q  <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wack_q  <= wack_d;
      regs_q  <= regs_d;
    end
  end

  assign oWack = wack_q;
  assign oBusy = (state_q == CLEAR);

  assign oR0  = '0;
  assign oR1  = regs_q[1];
  assign oR2  = regs_q[2];
  assign oR3  = regs_q[3];
  assign oR4  = regs_q[4];
  assign oR5  = regs_q[5];
  assign oR6  = regs_q[6];
  assign oR7  = regs_q[7];
  assign oR8  = regs_q[8];
  assign oR9  = regs_q[9];
  assign oR10 = regs_q[10];
  assign oR11 = regs_q[11];
  assign oR12 = regs_q[12];
  assign oR13 = regs_q[13];
  assign oR14 = regs_q[14];
  assign oR15 = regs_q[15];
  assign oR16 = regs_q[16];
  assign oR17 = regs_q[17];
  assign oR18 = regs_q[18];
  assign oR19 = regs_q[19];
  assign oR20 = regs_q[20];
  assign oR21 = regs_q[21];
  assign oR22 = regs_q[22];
  assign oR23 = regs_q[23];
  assign oR24 = regs_q[24];
  assign oR25 = regs_q[25];
  assign oR26 = regs_q[26];
  assign oR27 = regs_q[27];
  assign oR28 = regs_q[28];
  assign oR29 = regs_q[29];
  assign oR30 = regs_q[30];
  assign oR31 = regs_q[31];

endmodule

// File: tb/tb_regfile_bank32.sv
// Directed bench for regfile_bank32 with a write scoreboard and a
// reference copy of the register contents.
module tb_regfile_bank32;

  logic        clk;
  logic        rst_n;
  logic        iWe;
  logic [4:0]  iWaddr;
  logic [31:0] iWdata;
  logic [3:0]  iBe;
  logic        iClr;
  logic        oWack;
  logic        oBusy;
  logic [31:0] r_arr [32];

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  logic [31:0] mdl [32];

  typedef struct {
    int          idx;
    logic [31:0] val;
    logic        wack;
  } exp_t;
  exp_t sbq [$];

  regfile_bank32 #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .iWe(iWe), .iWaddr(iWaddr), .iWdata(iWdata),
    .iBe(iBe), .iClr(iClr), .oWack(oWack), .oBusy(oBusy),
    .oR0(r_arr[0]),   .oR1(r_arr[1]),   .oR2(r_arr[2]),   .oR3(r_arr[3]),
    .oR4(r_arr[4]),   .oR5(r_arr[5]),   .oR6(r_arr[6]),   .oR7(r_arr[7]),
    .oR8(r_arr[8]),   .oR9(r_arr[9]),   .oR10(r_arr[10]), .oR11(r_arr[11]),
    .oR12(r_arr[12]), .oR13(r_arr[13]), .oR14(r_arr[14]), .oR15(r_arr[15]),
    .oR16(r_arr[16]), .oR17(r_arr[17]), .oR18(r_arr[18]), .oR19(r_arr[19]),
    .oR20(r_arr[20]), .oR21(r_arr[21]), .oR22(r_arr[22]), .oR23(r_arr[23]),
    .oR24(r_arr[24]), .oR25(r_arr[25]), .oR26(r_arr[26]), .oR27(r_arr[27]),
    .oR28(r_arr[28]), .oR29(r_arr[29]), .oR30(r_arr[30]), .oR31(r_arr[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_r%0d", tag, i), r_arr[i], mdl[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    iWe  = 1'b0;
    iClr = 1'b0;
    tick();
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check($sformatf("wack_after_wr_r%0d", e.idx), 32'(oWack), 32'(e.wack));
      check($sformatf("data_after_wr_r%0d", e.idx), r_arr[e.idx], e.val);
    end
  endtask

  // Drive one write for one edge, update the reference, then check the result.
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    iWe    = 1'b1;
    iClr   = 1'b0;
    iWaddr = a[4:0];
    iWdata = d;
    iBe    = be;
    if (a != 0) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
      end
    end
    e.idx  = a;
    e.val  = mdl[a];
    e.wack = 1'b1;
    sbq.push_back(e);
    tick();
    iWe = 1'b0;
    pop_check();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    rst_n  = 1'b0;
    iWe    = 1'b0;
    iClr   = 1'b0;
    iWaddr = 5'd0;
    iWdata = 32'd0;
    iBe    = 4'h0;
    #12;
    rst_n = 1'b1;

    // Random prior contents, then a mid-cycle asynchronous reset.
    for (int k = 0; k < 6; k++) begin
      wr(int'($urandom_range(1, 31)), $urandom, 4'hF);
    end
    #1 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    #1;
    check_all_regs("async_rst");
    check("async_rst_wack", 32'(oWack), 32'd0);
    check("async_rst_busy", 32'(oBusy), 32'd0);
    #1 rst_n = 1'b1;

    // Byte-enable writes.
    wr(5, 32'hDEADBEEF, 4'hF);
    idle_cycle();
    check("wack_single_pulse", 32'(oWack), 32'd0);
    wr(5, 32'h11223344, 4'b0101);
    check("be_merge_r5", r_arr[5], 32'hDE22BE44);
    wr(6, 32'hFFFFFFFF, 4'h0);
    check("be_zero_r6", r_arr[6], 32'd0);

    // r0 is hardwired.
    wr(0, 32'hFFFFFFFF, 4'hF);
    check("r0_const", r_arr[0], 32'd0);

    // Back-to-back writes.
    wr(1, 32'd1, 4'hF);
    wr(2, 32'd2, 4'hF);
    wr(31, 32'h80000000, 4'hF);
    check("b2b_r1", r_arr[1], 32'd1);
    check("b2b_r2", r_arr[2], 32'd2);
    idle_cycle();
    check("b2b_wack_drop", 32'(oWack), 32'd0);

    // Same address twice keeps the last value.
    wr(12, 32'h0000AAAA, 4'hF);
    wr(12, 32'h0000BBBB, 4'hF);
    idle_cycle();
    check("same_addr_last", r_arr[12], 32'h0000BBBB);

    // Clear sequence with a simultaneous write that must be dropped.
    for (int a = 1; a < 32; a++) wr(a, 32'hA5A5A5A5, 4'hF);
    iClr   = 1'b1;
    iWe    = 1'b1;
    iWaddr = 5'd7;
    iWdata = 32'h00001234;
    iBe    = 4'hF;
    tick();
    check("clr_drop_wack", 32'(oWack), 32'd0);
    check("clr_drop_r7", r_arr[7], 32'hA5A5A5A5);
    check("clr_enter_busy", 32'(oBusy), 32'd1);
    busy_cnt = 0;
    for (int k = 1; k <= 31; k++) begin
      if (oBusy) busy_cnt++;
      iWe    = 1'b1;
      iWaddr = 5'd3;
      iWdata = 32'hFFFFFFFF;
      iBe    = 4'hF;
      iClr   = k[0];
      tick();
      mdl[k] = 32'd0;
      check($sformatf("clr_step_r%0d", k), r_arr[k], 32'd0);
      check($sformatf("clr_step_wack%0d", k), 32'(oWack), 32'd0);
      if (k < 31) begin
        check($sformatf("clr_ahead_r%0d", k + 1), r_arr[k + 1], mdl[k + 1]);
      end
    end
    iWe  = 1'b0;
    iClr = 1'b0;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_busy_end", 32'(oBusy), 32'd0);
    check_all_regs("clr_done");
    wr(9, 32'h0000CAFE, 4'hF);

    // Reset in the middle of a clear sequence.
    for (int a = 1; a < 32; a++) wr(a, 32'hA5A5A5A5, 4'hF);
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      mdl[k] = 32'd0;
    end
    check("midclr_r10", r_arr[10], 32'd0);
    check("midclr_r11", r_arr[11], 32'hA5A5A5A5);
    check("midclr_busy", 32'(oBusy), 32'd1);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    #1;
    check_all_regs("midclr_rst");
    check("midclr_rst_busy", 32'(oBusy), 32'd0);
    check("midclr_rst_wack", 32'(oWack), 32'd0);
    #1 rst_n = 1'b1;
    wr(20, 32'h00000055, 4'hF);
    idle_cycle();
    check("post_rst_busy", 32'(oBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bank32.md
Name: regfile_bank32

Overview:
- 32-entry x 32-bit general-purpose register storage.
- Sits directly upstream of the 32:1 register read selector: drives all 32 register values in parallel onto the selector's 32 data inputs.
- Provides one byte-enabled write port and a hardware bulk-clear sequencer.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8. Byte lanes NB = WIDTH/8.
- NREG, 32, number of registers; fixed at 32 to match the selector. Address width is 5.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- iWe  input  1  write request, sampled on rising clk.
- iWaddr  input  5  write register index.
- iWdata  input  WIDTH  write data.
- iBe  input  NB  byte enables; bit b qualifies iWdata[8b+7:8b].
- iClr  input  1  bulk-clear request, single-cycle pulse or level; sampled on rising clk.
- oWack  output  1  registered pulse: previous-cycle write was accepted.
- oBusy  output  1  high while the clear sequence runs.
- oR0 .. oR31  output  WIDTH each  current register contents; connect one-to-one to selector inputs 0..31.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers go to 0.
  - FSM goes to IDLE; clear counter goes to 0.
  - oWack=0, oBusy=0.
  - Takes effect immediately, regardless of clk.
- Reset deassertion: the first active edge is the first clk rise with rst_n=1.
- FSM states: IDLE, CLEAR.
- IDLE write:
  - Condition: iWe=1 and iClr=0 at a rising edge.
  - For each b with iBe[b]=1, reg[iWaddr] byte b <= iWdata byte b. Bytes with iBe[b]=0 keep their value.
  - oWack=1 for exactly the next cycle.
  - iWaddr=0: write is accepted (oWack=1) but has no effect; oR0 stays 0.
  - iBe=0: write is accepted (oWack=1) and no bytes change.
- Read latency:
  - oRn reflects a write starting the cycle after the edge.
  - There is no write-to-output bypass.
  - Outputs come straight from the registers; no combinational path from the write inputs to oRn.
- Back-to-back writes:
  - One write per cycle is sustained; oWack stays high across consecutive accepted writes.
  - Each write updates on its own edge, so the same address written twice leaves the last data.
- IDLE with iClr=1:
  - Enter CLEAR at that edge with counter=1.
  - A simultaneous iWe is dropped: no register change, oWack=0 next cycle.
  - Clear has priority.
- CLEAR:
  - Each edge: reg[counter] <= 0, counter += 1.
  - The edge with counter=31 clears reg[31] and returns to IDLE.
  - CLEAR lasts exactly 31 cycles.
  - oBusy=1 combinationally from FSM state, for all 31 cycles in CLEAR; 0 in IDLE.
- During CLEAR:
  - iWe is ignored and oWack stays 0; the requester must retry after oBusy falls.
  - iClr is ignored; the sequence does not restart.
  - Registers not yet reached keep their old values on the outputs.
- First cycle back in IDLE: writes are accepted normally.
- Counter is 5 bits and never wraps past 31 in use; value 0 is never cleared by the sequencer, since r0 is constant.
- Reset mid-CLEAR:
  - Asynchronously zeroes every register and returns to IDLE.
  - oBusy=0 immediately.
- oWack is a registered output, 0 in every cycle not following an accepted write.
- No X propagation on outputs after reset: every register holds an explicit value.

Test Plan:
- Reset value: hold rst_n=0 mid-cycle with random prior contents -> all oR0..oR31=0, oWack=0, oBusy=0, without waiting for a clk edge.
- Byte-enable write:
  - Write r5=0xDEADBEEF with iBe=4'hF -> next cycle oR5=0xDEADBEEF and oWack pulses for 1 cycle.
  - Then write 0x11223344 with iBe=4'b0101 -> oR5=0xDE22BE44.
- r0 hardwired: write r0=0xFFFFFFFF with iBe=4'hF -> oWack=1, oR0 stays 0.
- Back-to-back writes: write r1=1, r2=2, r31=0x80000000 on 3 consecutive edges -> oWack high for 3 cycles, all three values visible one cycle after each edge.
- Clear sequence:
  - Preload r1..r31 with 0xA5A5A5A5, then pulse iClr together with iWe (r7=0x1234) -> write dropped and oWack=0.
  - oBusy=1 for exactly 31 cycles.
  - r1 is zero after the first edge and r31 after the 31st.
  - Writes issued during CLEAR produce no change and oWack=0.
  - A write on the first IDLE cycle is accepted.
- Reset mid-clear: assert rst_n=0 at CLEAR cycle 10, when r11..r31 are still 0xA5A5A5A5 -> all outputs 0 and oBusy=0 immediately; after release, a write to r20=0x55 is accepted on the first edge.
